// File: rtl/dffrsnq_setclr_sequencer.sv
// Sequencer for a bank of async set/reset flops: turns set/clear commands into
// width-guaranteed, gap-separated, never-overlapping SETN_O/RN_O pulses.
module dffrsnq_setclr_sequencer #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_OP,
  output logic       REQ_READY,
  output logic       SETN_O,
  output logic       RN_O,
  output logic       CE,
  output logic       BUSY,
  output logic       DONE
);

  localparam int          MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_CS  = 2'b11;

  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("PULSE_CYC must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $error("GAP_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLR_PULSE,
    CLR_GAP,
    SET_PULSE,
    SET_GAP,
    FINISH
  } state_t;

  state_t             state_q, state_d, tgt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               rst_seq_q, rst_seq_d;
  logic               last;
  logic               setn_d, rn_d, ce_d, ready_d, done_d;

  // Next state: the counter holds remaining cycles of the current phase, so the
  // phase ends on the edge where it reads 1. FINISH is resolved to IDLE at once.
  always_comb begin
    tgt       = state_q;
    op_d      = op_q;
    rst_seq_d = rst_seq_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q - CNT_W'(1);
    last      = (cnt_q <= CNT_W'(1));

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          op_d      = REQ_OP;
          rst_seq_d = 1'b0;
          case (REQ_OP)
            OP_SET:        tgt = SET_PULSE;
            OP_CLR, OP_CS: tgt = CLR_PULSE;
            default:       tgt = FINISH;
          endcase
        end
      end
      CLR_PULSE: if (last) tgt = CLR_GAP;
      CLR_GAP:   if (last) tgt = (op_q == OP_CS && !rst_seq_q) ? SET_PULSE : FINISH;
      SET_PULSE: if (last) tgt = SET_GAP;
      SET_GAP:   if (last) tgt = FINISH;
      default:   tgt = IDLE;
    endcase

    state_d = tgt;
    if (tgt == FINISH) begin
      state_d = IDLE;
      done_d  = !rst_seq_d;
    end

    // Counter reloads on every phase entry and is parked at zero outside phases.
    case (state_d)
      CLR_PULSE, SET_PULSE: if (state_d != state_q) cnt_d = CNT_W'(PULSE_CYC);
      CLR_GAP, SET_GAP:     if (state_d != state_q) cnt_d = CNT_W'(GAP_CYC);
      default:              cnt_d = '0;
    endcase

    setn_d  = (state_d != SET_PULSE);
    rn_d    = (state_d != CLR_PULSE);
    ready_d = (state_d == IDLE);
    ce_d    = ready_d;
  end

  // Every output is a flop so the async pins of the bank never see a glitch.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q   <= CLR_PULSE;
      cnt_q     <= CNT_W'(PULSE_CYC);
      op_q      <= OP_CLR;
      rst_seq_q <= 1'b1;
      SETN_O    <= 1'b1;
      RN_O      <= 1'b0;
      CE        <= 1'b0;
      BUSY      <= 1'b1;
      REQ_READY <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rst_seq_q <= rst_seq_d;
      SETN_O    <= setn_d;
      RN_O      <= rn_d;
      CE        <= ce_d;
      BUSY      <= !ready_d;
      REQ_READY <= ready_d;
      DONE      <= done_d;
    end
  end

  logic unused_nop;
  assign unused_nop = ^OP_NOP;

endmodule

// File: tb/tb_dffrsnq_setclr_sequencer.sv
// Bench for dffrsnq_setclr_sequencer: per-cycle schedule model plus directed
// vectors with literal per-cycle output patterns.
module tb_dffrsnq_setclr_sequencer;

  localparam int P = 4;
  localparam int G = 2;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic [1:0] REQ_OP = 2'b00;
  logic       REQ_READY, SETN_O, RN_O, CE, BUSY, DONE;

  int n_run  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  dffrsnq_setclr_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .CLK(CLK), .RN(RN), .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP),
    .REQ_READY(REQ_READY), .SETN_O(SETN_O), .RN_O(RN_O), .CE(CE),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle: {setn, rn, ce, ready, done}
  typedef logic [4:0] exp_t;
  localparam exp_t E_IDLE = 5'b11110;
  localparam exp_t E_DONE = 5'b11111;
  localparam exp_t E_CLR  = 5'b10000;
  localparam exp_t E_SET  = 5'b01000;
  localparam exp_t E_GAP  = 5'b11000;

  exp_t q[$];
  exp_t cur = E_IDLE;
  bit   started = 1'b0;

  task automatic push_n(input int n, input exp_t e);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Model: each accepted command (or reset) becomes a queue of per-cycle outputs.
  always @(posedge CLK) begin
    if (!RN) begin
      q.delete();
      push_n(P, E_CLR);
      push_n(G, E_GAP);
      cur = q.pop_front();
      started = 1'b1;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur[1] && REQ_VALID) begin
      case (REQ_OP)
        2'b01: begin push_n(P, E_SET); push_n(G, E_GAP); end
        2'b10: begin push_n(P, E_CLR); push_n(G, E_GAP); end
        2'b11: begin
          push_n(P, E_CLR); push_n(G, E_GAP);
          push_n(P, E_SET); push_n(G, E_GAP);
        end
        default: ;
      endcase
      q.push_back(E_DONE);
      cur = q.pop_front();
    end else begin
      cur = E_IDLE;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("model_out", 16'({BUSY, SETN_O, RN_O, CE, REQ_READY, DONE}), 16'({~cur[1], cur}));
      check("never_both_low", 16'(SETN_O | RN_O), 16'd1);
    end
  end

  logic [15:0] v_setn, v_rn, v_ce, v_rdy, v_done;

  // Samples n cycles (bit 0 = first cycle after the preceding edge) and drives inputs.
  task automatic collect(input int n, input bit hold, input logic [1:0] hold_op,
                         input bit scramble, input int rst_at);
    v_setn = '0; v_rn = '0; v_ce = '0; v_rdy = '0; v_done = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      v_setn[i] = SETN_O;
      v_rn[i]   = RN_O;
      v_ce[i]   = CE;
      v_rdy[i]  = REQ_READY;
      v_done[i] = DONE;
      RN = (rst_at == i + 1) ? 1'b0 : 1'b1;
      if (scramble && i < 6) begin
        REQ_VALID = 1'($urandom);
        REQ_OP    = 2'($urandom);
      end else if (hold) begin
        REQ_VALID = 1'b1;
        REQ_OP    = hold_op;
      end else begin
        REQ_VALID = 1'b0;
      end
    end
  endtask

  task automatic accept(input logic [1:0] op);
    int k;
    k = 0;
    @(negedge CLK);
    while (!REQ_READY && k < 64) begin
      @(negedge CLK);
      k++;
    end
    if (!REQ_READY) begin
      n_run++;
      n_fail++;
      $display("FAIL accept_timeout: ready=%b required 1", REQ_READY);
    end
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    @(posedge CLK);
  endtask

  task automatic vec(input string tag, input logic [15:0] setn, input logic [15:0] rn,
                     input logic [15:0] ce, input logic [15:0] rdy, input logic [15:0] done);
    check({tag, "_setn"}, v_setn, setn);
    check({tag, "_rn"},   v_rn,   rn);
    check({tag, "_ce"},   v_ce,   ce);
    check({tag, "_rdy"},  v_rdy,  rdy);
    check({tag, "_done"}, v_done, done);
  endtask

  initial begin
    // Reset held for three edges, then the post-reset clear sequence without DONE
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", 16'({REQ_READY, SETN_O, RN_O, CE, BUSY, DONE}), 16'b010010);
    @(posedge CLK);
    collect(10, 1'b0, 2'b00, 1'b0, -1);
    vec("reset", 16'h03FF, 16'h03F0, 16'h03C0, 16'h03C0, 16'h0000);

    accept(2'b01);
    collect(8, 1'b0, 2'b00, 1'b0, -1);
    vec("op01", 16'h00F0, 16'h00FF, 16'h00C0, 16'h00C0, 16'h0040);

    accept(2'b11);
    collect(14, 1'b0, 2'b00, 1'b0, -1);
    vec("op11", 16'h3C3F, 16'h3FF0, 16'h3000, 16'h3000, 16'h1000);

    accept(2'b10);
    collect(14, 1'b1, 2'b01, 1'b0, -1);
    REQ_VALID = 1'b0;
    vec("b2b", 16'h387F, 16'h3FF0, 16'h2040, 16'h2040, 16'h2040);

    accept(2'b01);
    collect(12, 1'b0, 2'b00, 1'b0, 2);
    vec("midrst", 16'h0FFC, 16'h0FC3, 16'h0F00, 16'h0F00, 16'h0000);

    accept(2'b00);
    collect(3, 1'b0, 2'b00, 1'b0, -1);
    vec("op00", 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0001);

    accept(2'b01);
    collect(8, 1'b0, 2'b00, 1'b1, -1);
    vec("scramble", 16'h00F0, 16'h00FF, 16'h00C0, 16'h00C0, 16'h0040);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
